// File: rtl/apb_rr_arbiter_pkg.sv
// Shared state encoding and width helpers for the APB round-robin arbiter.
// Pure definitions: no latency, no flow control.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam int DefNumMst        = 3;
  localparam int DefAddrWidth     = 32;
  localparam int DefDataWidth     = 32;
  localparam int DefTimeoutCycles = 255;

  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of requester-side and downstream APB signals around the arbiter.
// master = arbiter view (drives downstream bus and requester responses); slave = environment view.
interface apb_rr_arbiter_if import apb_arb_pkg::*; #(
  parameter int NumMst    = DefNumMst,
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth
);

  logic [NumMst-1:0]           mst_psel_i;
  logic [NumMst-1:0]           mst_penable_i;
  logic [NumMst-1:0]           mst_pwrite_i;
  logic [NumMst*AddrWidth-1:0] mst_paddr_i;
  logic [NumMst*DataWidth-1:0] mst_pwdata_i;
  logic [DataWidth-1:0]        mst_prdata_o;
  logic [NumMst-1:0]           mst_pready_o;
  logic [NumMst-1:0]           mst_pslverr_o;

  logic                        psel_o;
  logic                        penable_o;
  logic                        pwrite_o;
  logic [AddrWidth-1:0]        paddr_o;
  logic [DataWidth-1:0]        pwdata_o;
  logic [DataWidth-1:0]        prdata_i;
  logic                        pready_i;
  logic                        pslverr_i;

  logic [NumMst-1:0]           grant_o;
  logic                        timeout_o;

  modport master (
    input  mst_psel_i, mst_penable_i, mst_pwrite_i, mst_paddr_i, mst_pwdata_i,
    input  prdata_i, pready_i, pslverr_i,
    output mst_prdata_o, mst_pready_o, mst_pslverr_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output grant_o, timeout_o
  );

  modport slave (
    output mst_psel_i, mst_penable_i, mst_pwrite_i, mst_paddr_i, mst_pwdata_i,
    output prdata_i, pready_i, pslverr_i,
    input  mst_prdata_o, mst_pready_o, mst_pslverr_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  grant_o, timeout_o
  );

endinterface

// File: rtl/apb_rr_arbiter_rr_sel.sv
// Round-robin pick: one-hot winner, searching upward from last_grant+1 with wrap.
// Purely combinational, no flow control.
module rr_sel import apb_arb_pkg::*; #(
  parameter int NumMst = DefNumMst,
  parameter int IdxW   = idx_width(NumMst)
) (
  input  logic [NumMst-1:0] req,
  input  logic [IdxW-1:0]   last_grant,
  output logic [NumMst-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NumMst; off++) begin
      idx = (int'(last_grant) + off) % NumMst;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one APB slave among NumMst requesters, round-robin; PSEL-in-IDLE to PREADY spans 4 cycles
// (IDLE/SETUP/ACCESS/DONE) with a zero-wait slave; downstream wait states stretch ACCESS up to TimeoutCycles.
module apb_rr_arbiter import apb_arb_pkg::*; #(
  parameter int NumMst        = DefNumMst,
  parameter int AddrWidth     = DefAddrWidth,
  parameter int DataWidth     = DefDataWidth,
  parameter int TimeoutCycles = DefTimeoutCycles
) (
  input  logic             clk_i,
  input  logic             rst_i,
  apb_rr_arbiter_if.master bus
);

  localparam int              IdxW      = idx_width(NumMst);
  localparam int              CntW      = cnt_width(TimeoutCycles);
  localparam bit              TimeoutEn = (TimeoutCycles > 0);
  localparam logic [CntW-1:0] CntLast   = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  arb_state_e           state, state_nxt;
  logic [IdxW-1:0]      last_grant, grant_idx;
  logic [CntW-1:0]      to_cnt;
  logic [NumMst-1:0]    winner;
  logic                 timeout_hit;
  logic [AddrWidth-1:0] win_addr;
  logic [DataWidth-1:0] win_wdata;
  logic                 win_write;
  logic                 unused_penable;

  // Requester PENABLE carries no information the arbiter needs.
  assign unused_penable = ^bus.mst_penable_i;

  rr_sel #(.NumMst(NumMst), .IdxW(IdxW)) u_rr_sel (
    .req       (bus.mst_psel_i),
    .last_grant(last_grant),
    .gnt       (winner)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE:   if (|bus.mst_psel_i) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        // A ready slave on the last allowed cycle still completes normally.
        if (bus.pready_i) begin
          state_nxt = DONE;
        end else if (TimeoutEn && to_cnt == CntLast) begin
          state_nxt   = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                to_cnt <= '0;
    else if (state == SETUP)                  to_cnt <= '0;
    else if (state == ACCESS && !bus.pready_i) to_cnt <= to_cnt + 1'b1;
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NumMst; i++) begin
      if (bus.grant_o[i]) grant_idx = IdxW'(i);
    end
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int i = 0; i < NumMst; i++) begin
      if (winner[i]) begin
        win_addr  = bus.mst_paddr_i[i*AddrWidth +: AddrWidth];
        win_wdata = bus.mst_pwdata_i[i*DataWidth +: DataWidth];
        win_write = bus.mst_pwrite_i[i];
      end
    end
  end

  // Every output is a flop loaded from the next state so it lines up with the FSM phase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.psel_o        <= 1'b0;
      bus.penable_o     <= 1'b0;
      bus.pwrite_o      <= 1'b0;
      bus.paddr_o       <= '0;
      bus.pwdata_o      <= '0;
      bus.grant_o       <= '0;
      bus.timeout_o     <= 1'b0;
      bus.mst_pready_o  <= '0;
      bus.mst_pslverr_o <= '0;
      bus.mst_prdata_o  <= '0;
      last_grant        <= IdxW'(NumMst - 1);
    end else begin
      bus.psel_o    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      bus.penable_o <= (state_nxt == ACCESS);
      bus.timeout_o <= timeout_hit;

      if (state == IDLE && state_nxt == SETUP) begin
        bus.grant_o  <= winner;
        bus.paddr_o  <= win_addr;
        bus.pwdata_o <= win_wdata;
        bus.pwrite_o <= win_write;
      end else if (state_nxt == IDLE) begin
        bus.grant_o <= '0;
      end

      if (state_nxt == DONE) begin
        bus.mst_pready_o  <= bus.grant_o;
        bus.mst_pslverr_o <= (timeout_hit || bus.pslverr_i) ? bus.grant_o : '0;
        bus.mst_prdata_o  <= timeout_hit ? '0 : bus.prdata_i;
      end else begin
        bus.mst_pready_o  <= '0;
        bus.mst_pslverr_o <= '0;
        bus.mst_prdata_o  <= '0;
      end

      if (state == DONE) last_grant <= grant_idx;
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed plus randomized transactions against a transaction-level model of the arbiter.
module tb_apb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_rr_arbiter_if #(.NumMst(N), .AddrWidth(AW), .DataWidth(DW)) bus();

  apb_rr_arbiter #(
    .NumMst(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int last_g   = N - 1;

  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  logic          write_a [N];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester order after last_g, wrapping; first one asking wins.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    int r;
    r = -1;
    for (int off = 1; off <= N; off++) begin
      if (r < 0 && req[(last + off) % N]) r = (last + off) % N;
    end
    return r;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = $urandom & 32'hFFFF_FFFC;
      wdata_a[i] = $urandom;
      write_a[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_payload();
    for (int i = 0; i < N; i++) begin
      bus.mst_paddr_i[i*AW +: AW]  = addr_a[i];
      bus.mst_pwdata_i[i*DW +: DW] = wdata_a[i];
      bus.mst_pwrite_i[i]          = write_a[i];
    end
  endtask

  // Whole transaction: starts and ends on a falling edge with the arbiter idle.
  // wait_c = ACCESS cycles the slave holds pready low before answering.
  task automatic do_txn(input logic [N-1:0] req, input int wait_c, input bit err,
                        input bit drop, input logic [DW-1:0] rdata);
    int w, n;
    bit to;
    logic [N-1:0] oh;
    w  = rr_pick(req, last_g);
    oh = N'(1) << w;
    to = (wait_c >= TO);
    n  = to ? TO : wait_c + 1;

    drive_payload();
    bus.mst_psel_i = req;
    bus.mst_penable_i = '0;
    bus.pready_i   = 1'b0;
    bus.prdata_i   = rdata;
    bus.pslverr_i  = err;

    tick();
    check("setup_psel",    bus.psel_o,       1);
    check("setup_penable", bus.penable_o,    0);
    check("setup_grant",   bus.grant_o,      oh);
    check("setup_paddr",   bus.paddr_o,      addr_a[w]);
    check("setup_pwdata",  bus.pwdata_o,     wdata_a[w]);
    check("setup_pwrite",  bus.pwrite_o,     write_a[w]);
    check("setup_pready",  bus.mst_pready_o, 0);
    bus.mst_penable_i = req;

    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1 && drop) bus.mst_psel_i[w] = 1'b0;
      check("access_psel",    bus.psel_o,       1);
      check("access_penable", bus.penable_o,    1);
      check("access_paddr",   bus.paddr_o,      addr_a[w]);
      check("access_pready",  bus.mst_pready_o, 0);
      check("access_prdata",  bus.mst_prdata_o, 0);
      check("access_timeout", bus.timeout_o,    0);
      bus.pready_i = (k == wait_c + 1);
    end

    tick();
    check("done_pready",  bus.mst_pready_o,  oh);
    check("done_pslverr", bus.mst_pslverr_o, (to || err) ? oh : '0);
    check("done_prdata",  bus.mst_prdata_o,  to ? '0 : rdata);
    check("done_timeout", bus.timeout_o,     to);
    check("done_psel",    bus.psel_o,        0);
    check("done_penable", bus.penable_o,     0);
    last_g = w;
    bus.pready_i      = 1'b0;
    bus.mst_psel_i    = '0;
    bus.mst_penable_i = '0;

    tick();
    check("idle_grant",   bus.grant_o,      0);
    check("idle_pready",  bus.mst_pready_o, 0);
    check("idle_prdata",  bus.mst_prdata_o, 0);
    check("idle_timeout", bus.timeout_o,    0);
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b0;
    bus.mst_psel_i    = '0;
    bus.mst_penable_i = '0;
    bus.mst_pwrite_i  = '0;
    bus.mst_paddr_i   = '0;
    bus.mst_pwdata_i  = '0;
    bus.prdata_i      = '0;
    bus.pready_i      = 1'b0;
    bus.pslverr_i     = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_psel",    bus.psel_o,        0);
    check("rst_penable", bus.penable_o,     0);
    check("rst_grant",   bus.grant_o,       0);
    check("rst_pready",  bus.mst_pready_o,  0);
    check("rst_pslverr", bus.mst_pslverr_o, 0);
    check("rst_prdata",  bus.mst_prdata_o,  0);
    check("rst_timeout", bus.timeout_o,     0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full contention from reset: grants go 0,1,2,0.
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      do_txn(3'b111, 0, 1'b0, 1'b0, $urandom);
    end

    // Single zero-wait write from requester 1.
    rand_payload();
    addr_a[1] = 32'h0000_000C; wdata_a[1] = 32'hDEAD_BEEF; write_a[1] = 1'b1;
    do_txn(3'b010, 0, 1'b0, 1'b0, 32'h0);

    // Read with five wait states.
    rand_payload();
    write_a[2] = 1'b0;
    do_txn(3'b100, 5, 1'b0, 1'b0, 32'h0000_1234);

    // Slave never answers: timeout after TO ACCESS cycles.
    rand_payload();
    do_txn(3'b001, 20, 1'b0, 1'b0, 32'hCAFE_F00D);

    // Ready arrives in the last allowed cycle: normal completion with slave error.
    rand_payload();
    do_txn(3'b010, TO - 1, 1'b1, 1'b0, 32'h0000_55AA);

    // Owner drops PSEL mid-transfer; transfer still finishes.
    rand_payload();
    do_txn(3'b101, 2, 1'b0, 1'b1, 32'h0000_0077);

    // Reset during ACCESS.
    rand_payload();
    drive_payload();
    bus.mst_psel_i = 3'b110;
    tick();
    tick();
    check("pre_rst_penable", bus.penable_o, 1);
    rst = 1'b1;
    #1;
    check("arst_psel",    bus.psel_o,    0);
    check("arst_penable", bus.penable_o, 0);
    check("arst_grant",   bus.grant_o,   0);
    @(posedge clk);
    #1;
    check("arst_pready", bus.mst_pready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    last_g = N - 1;
    bus.mst_psel_i = '0;
    rand_payload();
    do_txn(3'b111, 1, 1'b0, 1'b0, $urandom);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      rand_payload();
      r = N'($urandom_range(1, (1 << N) - 1));
      do_txn(r, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
